alu_iter_exec: RTL and testbench
================================

Name: alu_iter_exec

Overview:
- Execute-stage unit directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code plus two operands and produces a registered result and zero flag.
- Single-cycle ops complete with latency 1. mul (code 4'b1111) runs as an iterative radix-2 shift-add.
- Start/ready/valid handshake so the CPU can stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request; accepted only when ready_o=1.
- ctrl_i  input  4  ALU control code; sampled on accept.
- src1_i  input  WIDTH  operand 1; sampled on accept.
- src2_i  input  WIDTH  operand 2; sampled on accept.
- shamt_i  input  5  shift amount; sampled on accept.
- ready_o  output  1  high in IDLE only.
- valid_o  output  1  one-cycle pulse; result_o/zero_o valid.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  registered flag.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; ready_o=1; valid_o=0; result_o=0; zero_o=0.
  - Accumulator, multiplicand, multiplier and counter cleared.
  - Reset mid-RUN abandons the op; no valid_o is produced.
- States:
  - IDLE: start_i=1 captures the inputs. ctrl_i==4'b1111 -> RUN; otherwise compute, load result_o -> DONE.
  - RUN: each cycle, if multiplier[0]=1 then acc+=multiplicand. Then multiplicand<<=1, multiplier>>=1, cnt++. When cnt reaches WIDTH-1 (last iteration), load result_o -> DONE.
  - DONE: valid_o=1 for exactly this cycle, ready_o=0; next state IDLE.
- Latency, counted from the accepting edge:
  - Non-mul: valid_o high in the following cycle (latency 1).
  - mul: valid_o high WIDTH+1 cycles after accept (33 for WIDTH=32).
- Holding and back-to-back:
  - result_o/zero_o hold their value after DONE until the next result is loaded.
  - start_i while ready_o=0 is ignored, not queued.
  - Back-to-back issue is possible on the cycle after DONE.
- Op codes (all arithmetic modulo 2**WIDTH, operands as captured):
  - 0000: and.
  - 0001: or.
  - 0010: add.
  - 0110: sub.
  - 0111: slt, signed (result 1 or 0).
  - 0011: lui, src2<<16.
  - 1000: sra, src2>>>shamt.
  - 1011: srav, src2>>>src1[4:0].
  - 1001: bne, src1-src2.
  - 1101: jr, pass src1.
  - 1111: mul, low WIDTH bits of the product; identical for signed and unsigned.
  - Any other code: result 0, latency 1.
- zero_o:
  - (result==0) for all codes except 1001.
  - For 1001, zero_o = (result!=0), i.e. the branch-taken flag.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined: RUN exits to DONE at the end of the first iteration in which the post-shift multiplier is zero, or at cnt=WIDTH-1, whichever comes first.
  - RUN length = max(1, index of highest set bit of src2 + 1) cycles.
  - src2=0 gives 1 RUN cycle; valid_o arrives 2 cycles after accept.
- Undefined: RUN is always exactly WIDTH cycles, independent of the operand values.
- Result values are identical in both builds.

Test Plan:
- Reset: assert rst_i mid-RUN of a mul -> ready_o=1, valid_o=0, result_o=0 immediately; no valid_o afterwards.
- add: ctrl=0010, src1=0xFFFFFFFF, src2=1 -> next cycle valid_o=1, result_o=0, zero_o=1.
- sub/bne:
  - ctrl=0110, src1=5, src2=5 -> result_o=0, zero_o=1.
  - ctrl=1001, same operands -> zero_o=0.
  - ctrl=1001, src1=5, src2=3 -> result_o=2, zero_o=1.
- sra/slt:
  - ctrl=1000, src2=0x80000000, shamt=4 -> result_o=0xF8000000.
  - ctrl=0111, src1=0xFFFFFFFF, src2=1 -> result_o=1.
- mul:
  - ctrl=1111, src1=0xFFFFFFFF, src2=3 -> result_o=0xFFFFFFFD, valid_o exactly 33 cycles after accept (without macro).
  - start_i held high during RUN -> ignored.
- Early termination (MUL_EARLY_TERM_EN):
  - src1=7, src2=6 -> result_o=42, valid_o 4 cycles after accept.
  - src2=0 -> result_o=0, valid_o 2 cycles after accept.

Source files
------------

// File: rtl/alu_iter_exec.sv
// rtl/alu_iter_exec.sv - execute-stage ALU with single-cycle ops and iterative shift-add mul
// Optional: define MUL_EARLY_TERM_EN to end mul RUN once the remaining multiplier is zero.
module alu_iter_exec #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       shamt_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LUI  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_SRAV = 4'b1011;
  localparam logic [3:0] OP_JR   = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] mplier_shr;
  logic             run_last;

  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_ADD:  alu_res = src1_i + src2_i;
      OP_SUB:  alu_res = src1_i - src2_i;
      OP_SLT:  alu_res = ($signed(src1_i) < $signed(src2_i)) ? WIDTH'(1) : '0;
      OP_LUI:  alu_res = src2_i << 16;
      OP_SRA:  alu_res = $signed(src2_i) >>> shamt_i;
      OP_SRAV: alu_res = $signed(src2_i) >>> src1_i[4:0];
      OP_BNE:  alu_res = src1_i - src2_i;
      OP_JR:   alu_res = src1_i;
      default: alu_res = '0;
    endcase
  end

  // One radix-2 step: add the shifted multiplicand when the current multiplier bit is set.
  assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mplier_shr = mplier_q >> 1;

`ifdef MUL_EARLY_TERM_EN
  assign run_last = (mplier_shr == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`else
  assign run_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (ctrl_i == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = src1_i;
            mplier_d = src2_i;
            cnt_d    = '0;
            state_d  = RUN;
          end else begin
            result_d = alu_res;
            // bne reports branch-taken rather than equality
            zero_d   = (ctrl_i == OP_BNE) ? (alu_res != '0) : (alu_res == '0);
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CNT_W'(1);
        if (run_last) begin
          result_d = acc_sum;
          zero_d   = (acc_sum == '0);
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// tb/tb_alu_iter_exec.sv - self-checking bench for alu_iter_exec (honours MUL_EARLY_TERM_EN)
module tb_alu_iter_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  shamt;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic        zero_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_iter_exec #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .ctrl_i   (ctrl),
    .src1_i   (src1),
    .src2_i   (src2),
    .shamt_i  (shamt),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .zero_o   (zero_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] s, output logic [31:0] r, output logic z,
                                output int lat);
    int msb;
    lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = b << 16;
      4'b1000: r = $signed(b) >>> s;
      4'b1011: r = $signed(b) >>> a[4:0];
      4'b1001: r = a - b;
      4'b1101: r = a;
      4'b1111: begin
        r = a * b;
`ifdef MUL_EARLY_TERM_EN
        msb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        lat = (msb < 0) ? 2 : msb + 2;
`else
        msb = 31;
        lat = msb + 2;
`endif
      end
      default: r = 32'd0;
    endcase
    z = (c == 4'b1001) ? (r != 0) : (r == 0);
  endfunction

  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s, input bit hold, input string tag);
    logic [31:0] er;
    logic        ez;
    int          el;
    int          lat;
    model(c, a, b, s, er, ez, el);
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    start = 1'b1; ctrl = c; src1 = a; src2 = b; shamt = s;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    src1 = $urandom; src2 = $urandom; shamt = 5'($urandom);
    lat = 1;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_res"}, result_o, er);
    chk({tag, "_zero"}, {31'd0, zero_o}, {31'd0, ez});
    chk({tag, "_busy"}, {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_hold"}, result_o, er);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    logic [3:0] rc;
    bit seen;
    rst = 1'b1; start = 1'b0; ctrl = 4'd0; src1 = 32'd0; src2 = 32'd0; shamt = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_zero", {31'd0, zero_o}, 32'd0);
    rst = 1'b0;

    do_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, "add_wrap");
    chk("add_wrap_zero_const", {31'd0, zero_o}, 32'd1);
    do_op(4'b0110, 32'd5, 32'd5, 5'd0, 1'b0, "sub_eq");
    do_op(4'b1001, 32'd5, 32'd5, 5'd0, 1'b0, "bne_eq");
    do_op(4'b1001, 32'd5, 32'd3, 5'd0, 1'b0, "bne_ne");
    chk("bne_ne_res_const", result_o, 32'd2);
    do_op(4'b1000, 32'd0, 32'h8000_0000, 5'd4, 1'b0, "sra");
    chk("sra_const", result_o, 32'hF800_0000);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, "slt");
    chk("slt_const", result_o, 32'd1);
    do_op(4'b1011, 32'd3, 32'h8000_00F0, 5'd0, 1'b0, "srav");
    do_op(4'b0011, 32'd0, 32'h0000_ABCD, 5'd0, 1'b0, "lui");
    do_op(4'b1101, 32'h1234_5678, 32'd0, 5'd0, 1'b0, "jr");
    do_op(4'b0100, 32'h1234_5678, 32'h1, 5'd0, 1'b0, "undef");
    do_op(4'b1111, 32'hFFFF_FFFF, 32'd3, 5'd0, 1'b1, "mul_hold");
    chk("mul_res_const", result_o, 32'hFFFF_FFFD);
    do_op(4'b1111, 32'd7, 32'd6, 5'd0, 1'b0, "mul_7x6");
    chk("mul_7x6_const", result_o, 32'd42);
    do_op(4'b1111, 32'h1234_5678, 32'd0, 5'd0, 1'b0, "mul_zero");

    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom_range(0, 15));
      do_op(rc, $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom,
            5'($urandom), 1'($urandom), $sformatf("rnd%0d_op%0h", i, rc));
    end

    @(negedge clk);
    start = 1'b1; ctrl = 4'b1111; src1 = 32'hFFFF_FFFF; src2 = 32'h8000_0003;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_rst_ready", {31'd0, ready_o}, 32'd1);
    chk("midrun_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrun_rst_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    chk("midrun_no_valid", {31'd0, seen}, 32'd0);
    chk("midrun_idle", {31'd0, ready_o}, 32'd1);

    do_op(4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 1'b0, "or_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
